lookup_cfg_writer: RTL and testbench
====================================

LOOKUP_CFG_WRITER -- requirements
Module: lookup_cfg_writer

Interface
REQ-001 Parameter STAGE, default 0: stage ID this writer answers to.
REQ-002 Parameter C_DATA_W, default 256: control-stream word width.
REQ-003 Parameter ACT_LEN, default 25: action slot width; action entry = ACT_LEN*25 = 625 bits.
REQ-004 Port list: one clock; reset is asynchronous and active-high.
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ctrl_data  in  C_DATA_W  control-stream word.
- ctrl_valid  in  1  word valid.
- ctrl_last  in  1  last word of control packet.
- ctrl_ready  out  1  writer accepts word.
- lookup_din  out  1024  CAM entry data.
- lookup_din_mask  out  1024  CAM entry mask.
- lookup_din_addr  out  4  CAM entry index.
- lookup_din_en  out  1  one-cycle CAM write strobe.
- action_data_in  out  625  action RAM entry.
- action_addr  out  4  action RAM index.
- action_en  out  1  one-cycle action RAM write strobe.
- cfg_err_cnt  out  16  saturating count of malformed/dropped packets.

Function
REQ-005 A word is accepted in any cycle where ctrl_valid and ctrl_ready are both 1.
REQ-006 The first accepted word of a packet is the header: [7:0] stage, [9:8] target (00 = CAM, 01 = action), [13:10] addr; all other bits are ignored.
REQ-007 Payload words are packed little-endian: the first payload word fills bits [255:0], the next fills [511:256], and so on.
REQ-008 CAM payload is 8 words: words 1-4 carry lookup_din; words 5-8 carry lookup_din_mask.
REQ-009 Action payload is 3 words: action_data_in takes bits [624:0]; bits [767:625] are discarded.
REQ-010 FSM states: IDLE, CAM_DATA, ACT_DATA, WRITE, DRAIN; word counter 3 bits wide.
REQ-011 IDLE, header accepted with ctrl_last=1: packet is dropped; err counts +1; stay IDLE.
REQ-012 IDLE, header stage != STAGE: go to DRAIN; not an error.
REQ-013 IDLE, target 1x: go to DRAIN; err +1.
REQ-014 IDLE, header otherwise: latch addr; go to CAM_DATA or ACT_DATA; counter = 0.
REQ-015 CAM_DATA/ACT_DATA: each accepted word is stored and the counter increments.
REQ-016 ctrl_last on a payload word before the final word: partial data is discarded, no write occurs, err +1, go to IDLE.
REQ-017 Final payload word accepted: go to WRITE; set a flag if that word did not carry ctrl_last.
REQ-018 WRITE lasts exactly one cycle; ctrl_ready=0; the matching strobe (lookup_din_en or action_en) is 1.
REQ-019 After WRITE: go to DRAIN if the flag is set, else go to IDLE.
REQ-020 DRAIN: ctrl_ready=1; words are discarded until the word with ctrl_last is accepted, then go to IDLE.
REQ-021 Latency: the strobe asserts the cycle after the final payload word is accepted.
REQ-022 The addr and data outputs are valid during the strobe and hold their values until the next write of the same target.
REQ-023 ctrl_ready is 1 in every state except WRITE.
REQ-024 cfg_err_cnt saturates at 16'hFFFF.
REQ-025 A new packet's header is accepted no earlier than the cycle after the previous packet's WRITE or last word.

Reset
REQ-026 rst=1 forces IDLE, counter 0, flag 0, and all outputs 0, including ctrl_ready and cfg_err_cnt.
REQ-027 ctrl_ready becomes 1 on the first clock edge after rst deasserts.
REQ-028 Reset mid-packet: the partial entry is lost, no strobe is issued, and the first word after reset is treated as a header.

Structure
REQ-029 A shared package holds: target codes, header field offsets, CAM_WORDS=8, ACT_WORDS=3, and the 1024/625 entry widths.
REQ-030 Payload assembly is a sub-module, cfg_word_packer: a word-indexed shift/load register, parameterised by word count and output width.
REQ-031 The writer FSM, counters and error counter live in lookup_cfg_writer.

Verification
REQ-032 Directed scenarios:
- CAM write: header stage=0 target=00 addr=5, then 8 words 0x1..0x8, last on word 8 -> one lookup_din_en pulse the cycle after word 8; addr=5; lookup_din low word=0x1; mask low word=0x5; cfg_err_cnt=0.
- Action write: target=01 addr=0xF, 3 words all-ones -> one action_en pulse; action_data_in = 625 ones; action_addr=0xF.
- Stage mismatch: stage=3 when STAGE=0, 9 words -> no strobe; cfg_err_cnt unchanged; next valid packet writes normally.
- Short packet: CAM header + 4 words, last on word 4 -> no strobe; cfg_err_cnt=1.
- Overlong action packet: 5 payload words -> action_en once, after word 3; words 4-5 drained; ctrl_ready=0 only in the WRITE cycle.
- Reset mid-CAM-payload after word 3 -> no strobe; all outputs 0; a following full packet writes correctly.

Source files
------------

// File: rtl/lookup_cfg_writer_pkg.sv
// Shared constants for the lookup configuration writer: header layout,
// target codes, payload word counts and table entry widths.
package lookup_cfg_writer_pkg;

  localparam logic [1:0] TGT_CAM = 2'b00;
  localparam logic [1:0] TGT_ACT = 2'b01;

  localparam int HDR_STAGE_LSB = 0;
  localparam int HDR_STAGE_W   = 8;
  localparam int HDR_TGT_LSB   = 8;
  localparam int HDR_TGT_W     = 2;
  localparam int HDR_ADDR_LSB  = 10;
  localparam int HDR_ADDR_W    = 4;

  localparam int CAM_WORDS   = 8;
  localparam int ACT_WORDS   = 3;
  localparam int CNT_W       = 3;
  localparam int CAM_ENTRY_W = 1024;
  localparam int ACT_ENTRY_W = 625;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAM_DATA,
    ST_ACT_DATA,
    ST_WRITE,
    ST_DRAIN
  } wr_state_t;

endpackage

// File: rtl/cfg_word_packer.sv
// Word-indexed load register: word i of the payload lands in bits
// [i*WORD_W +: WORD_W], giving little-endian packing of a multi-word entry.
module cfg_word_packer #(
  parameter int WORD_W  = 256,
  parameter int N_WORDS = 8,
  parameter int OUT_W   = WORD_W * N_WORDS,
  parameter int IDX_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_word,
  output logic [OUT_W-1:0]  o_data
);

  logic [WORD_W*N_WORDS-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data[int'(i_idx)*WORD_W +: WORD_W] <= i_word;
    end
  end

  assign o_data = r_data[OUT_W-1:0];

endmodule

// File: rtl/lookup_cfg_writer.sv
// Control-stream consumer that assembles CAM and action-RAM entries from
// multi-word packets and issues one-cycle write strobes.
module lookup_cfg_writer
  import lookup_cfg_writer_pkg::*;
#(
  parameter int STAGE    = 0,
  parameter int C_DATA_W = 256,
  parameter int ACT_LEN  = 25
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [C_DATA_W-1:0]      ctrl_data,
  input  logic                     ctrl_valid,
  input  logic                     ctrl_last,
  output logic                     ctrl_ready,
  output logic [CAM_ENTRY_W-1:0]   lookup_din,
  output logic [CAM_ENTRY_W-1:0]   lookup_din_mask,
  output logic [HDR_ADDR_W-1:0]    lookup_din_addr,
  output logic                     lookup_din_en,
  output logic [ACT_LEN*25-1:0]    action_data_in,
  output logic [HDR_ADDR_W-1:0]    action_addr,
  output logic                     action_en,
  output logic [15:0]              cfg_err_cnt,
  output logic [2:0]               o_dbg_state
);

  localparam int ACT_W = ACT_LEN * 25;
  localparam logic [HDR_STAGE_W-1:0] STAGE_ID = STAGE[HDR_STAGE_W-1:0];

  // Handshake: a word moves when ctrl_valid and ctrl_ready are both high on a
  // rising edge; ctrl_ready is registered and drops only for the WRITE cycle.

  wr_state_t              r_state;
  wr_state_t              w_next_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_next_cnt;
  logic                   r_flag;
  logic                   w_next_flag;
  logic                   r_ready;
  logic                   r_is_act;
  logic [HDR_ADDR_W-1:0]  r_hdr_addr;
  logic [15:0]            r_err_cnt;
  logic [CAM_ENTRY_W-1:0] r_cam_din;
  logic [CAM_ENTRY_W-1:0] r_cam_mask;
  logic [HDR_ADDR_W-1:0]  r_cam_addr;
  logic [ACT_W-1:0]       r_act_data;
  logic [HDR_ADDR_W-1:0]  r_act_addr;

  logic                   w_accept;
  logic                   w_err_inc;
  logic                   w_hdr_latch;
  logic                   w_load;
  logic [CNT_W-1:0]       w_final_idx;
  logic [HDR_STAGE_W-1:0] w_hdr_stage;
  logic [HDR_TGT_W-1:0]   w_hdr_tgt;
  logic [HDR_ADDR_W-1:0]  w_hdr_addr;
  logic [2*CAM_ENTRY_W-1:0] w_packed;
  logic                   w_cam_wr;
  logic                   w_act_wr;

  assign w_accept    = ctrl_valid && r_ready;
  assign w_hdr_stage = ctrl_data[HDR_STAGE_LSB +: HDR_STAGE_W];
  assign w_hdr_tgt   = ctrl_data[HDR_TGT_LSB +: HDR_TGT_W];
  assign w_hdr_addr  = ctrl_data[HDR_ADDR_LSB +: HDR_ADDR_W];
  assign w_final_idx = (r_state == ST_ACT_DATA) ? CNT_W'(ACT_WORDS - 1)
                                                : CNT_W'(CAM_WORDS - 1);

  cfg_word_packer #(
    .WORD_W  (C_DATA_W),
    .N_WORDS (CAM_WORDS),
    .OUT_W   (2 * CAM_ENTRY_W),
    .IDX_W   (CNT_W)
  ) u_packer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_idx  (r_cnt),
    .i_word (ctrl_data),
    .o_data (w_packed)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_flag  = r_flag;
    w_err_inc    = 1'b0;
    w_hdr_latch  = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (ctrl_last) begin
            w_err_inc = 1'b1;
          end else if (w_hdr_stage != STAGE_ID) begin
            w_next_state = ST_DRAIN;
          end else if (w_hdr_tgt[1]) begin
            w_next_state = ST_DRAIN;
            w_err_inc    = 1'b1;
          end else begin
            w_hdr_latch  = 1'b1;
            w_next_cnt   = '0;
            w_next_flag  = 1'b0;
            w_next_state = (w_hdr_tgt == TGT_ACT) ? ST_ACT_DATA : ST_CAM_DATA;
          end
        end
      end
      ST_CAM_DATA, ST_ACT_DATA: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (r_cnt == w_final_idx) begin
            w_next_state = ST_WRITE;
            w_next_flag  = !ctrl_last;
          end else if (ctrl_last) begin
            // Packet ended early: the partial entry is simply never written.
            w_next_state = ST_IDLE;
            w_err_inc    = 1'b1;
          end else begin
            w_next_cnt = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_WRITE: begin
        w_next_flag  = 1'b0;
        w_next_state = r_flag ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (w_accept && ctrl_last) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_flag     <= 1'b0;
      r_ready    <= 1'b0;
      r_is_act   <= 1'b0;
      r_hdr_addr <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_flag  <= w_next_flag;
      r_ready <= (w_next_state != ST_WRITE);
      if (w_hdr_latch) begin
        r_is_act   <= (w_hdr_tgt == TGT_ACT);
        r_hdr_addr <= w_hdr_addr;
      end
      if (w_err_inc && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign w_cam_wr = (r_state == ST_WRITE) && !r_is_act;
  assign w_act_wr = (r_state == ST_WRITE) && r_is_act;

  // The hold registers capture the entry during WRITE; the outputs bypass
  // them in that cycle so data is already valid alongside the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cam_din  <= '0;
      r_cam_mask <= '0;
      r_cam_addr <= '0;
      r_act_data <= '0;
      r_act_addr <= '0;
    end else begin
      if (w_cam_wr) begin
        r_cam_din  <= w_packed[CAM_ENTRY_W-1:0];
        r_cam_mask <= w_packed[2*CAM_ENTRY_W-1:CAM_ENTRY_W];
        r_cam_addr <= r_hdr_addr;
      end
      if (w_act_wr) begin
        r_act_data <= w_packed[ACT_W-1:0];
        r_act_addr <= r_hdr_addr;
      end
    end
  end

  assign ctrl_ready      = r_ready;
  assign lookup_din_en   = w_cam_wr;
  assign action_en       = w_act_wr;
  assign lookup_din      = w_cam_wr ? w_packed[CAM_ENTRY_W-1:0] : r_cam_din;
  assign lookup_din_mask = w_cam_wr ? w_packed[2*CAM_ENTRY_W-1:CAM_ENTRY_W] : r_cam_mask;
  assign lookup_din_addr = w_cam_wr ? r_hdr_addr : r_cam_addr;
  assign action_data_in  = w_act_wr ? w_packed[ACT_W-1:0] : r_act_data;
  assign action_addr     = w_act_wr ? r_hdr_addr : r_act_addr;
  assign cfg_err_cnt     = r_err_cnt;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_lookup_cfg_writer.sv
// Self-checking bench for lookup_cfg_writer: directed packets then random
// packets, checked against a packet-level reference model.
module tb_lookup_cfg_writer;

  localparam int DW   = 256;
  localparam int SB_W = 1 + 4 + 2048;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DW-1:0]   ctrl_data = '0;
  logic            ctrl_valid = 1'b0;
  logic            ctrl_last = 1'b0;
  logic            ctrl_ready;
  logic [1023:0]   lookup_din;
  logic [1023:0]   lookup_din_mask;
  logic [3:0]      lookup_din_addr;
  logic            lookup_din_en;
  logic [624:0]    action_data_in;
  logic [3:0]      action_addr;
  logic            action_en;
  logic [15:0]     cfg_err_cnt;
  logic [2:0]      dbg_state;

  always #5 clk = ~clk;

  lookup_cfg_writer #(.STAGE(0), .C_DATA_W(DW), .ACT_LEN(25)) dut (
    .clk             (clk),
    .rst             (rst),
    .ctrl_data       (ctrl_data),
    .ctrl_valid      (ctrl_valid),
    .ctrl_last       (ctrl_last),
    .ctrl_ready      (ctrl_ready),
    .lookup_din      (lookup_din),
    .lookup_din_mask (lookup_din_mask),
    .lookup_din_addr (lookup_din_addr),
    .lookup_din_en   (lookup_din_en),
    .action_data_in  (action_data_in),
    .action_addr     (action_addr),
    .action_en       (action_en),
    .cfg_err_cnt     (cfg_err_cnt),
    .o_dbg_state     (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int              n_cmp = 0;
  int              n_bad = 0;
  logic [SB_W-1:0] exp_q[$];
  logic [DW-1:0]   pkt[$];
  logic [15:0]     m_err = '0;
  logic [1023:0]   m_cam_din = '0;
  logic [1023:0]   m_cam_mask = '0;
  logic [3:0]      m_cam_addr = '0;
  logic [624:0]    m_act_data = '0;
  logic [3:0]      m_act_addr = '0;
  bit              mon_en = 1'b0;
  logic [SB_W-1:0] mon_obs;

  task automatic check(input string tag, input logic [SB_W-1:0] obs, input logic [SB_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (low 128 bits shown)", tag, obs[127:0], exp[127:0]);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (lookup_din_en || action_en || !ctrl_ready)
        check("ready_low_only_in_write", {ctrl_ready, lookup_din_en ^ action_en}, 2'b01);
      if (lookup_din_en || action_en) begin
        mon_obs = '0;
        if (action_en) begin
          mon_obs[SB_W-1]     = 1'b1;
          mon_obs[SB_W-2 -: 4] = action_addr;
          mon_obs[624:0]      = action_data_in;
        end else begin
          mon_obs[SB_W-2 -: 4] = lookup_din_addr;
          mon_obs[2047:0]     = {lookup_din_mask, lookup_din};
        end
        check("strobe_expected", SB_W'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("strobe_entry", mon_obs, exp_q.pop_front());
      end
    end
  end

  // ---------------- helpers / drivers ----------------
  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [DW-1:0] make_hdr(input int stage, input int tgt, input int addr);
    logic [DW-1:0] w;
    logic [7:0] s;
    logic [1:0] t;
    logic [3:0] a;
    w = rand_word();
    s = stage[7:0];
    t = tgt[1:0];
    a = addr[3:0];
    w[7:0] = s;
    w[9:8] = t;
    w[13:10] = a;
    return w;
  endfunction

  task automatic err_inc();
    if (m_err != 16'hFFFF) m_err++;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic l);
    int tries;
    bit acc;
    tries = 0;
    acc = 1'b0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
    ctrl_data  = d;
    ctrl_last  = l;
    ctrl_valid = 1'b1;
    while (!acc) begin
      acc = ctrl_ready;
      @(negedge clk);
      tries++;
      if (!acc && tries > 20) begin
        check("ready_timeout", 0, 1);
        break;
      end
    end
    ctrl_valid = 1'b0;
    ctrl_last  = 1'b0;
  endtask

  // Applies the packet rules to the whole packet, then sends it.
  task automatic send_packet();
    logic [DW-1:0]   hdr;
    logic [2047:0]   payload;
    logic [SB_W-1:0] e;
    logic [3:0]      addr;
    int  n, need;
    bit  wr, is_act;
    hdr     = pkt[0];
    n       = pkt.size();
    need    = 0;
    wr      = 1'b0;
    payload = '0;
    addr    = hdr[13:10];
    is_act  = (hdr[9:8] == 2'b01);
    if (n == 1) begin
      err_inc();
    end else if (hdr[7:0] == 8'd0) begin
      if (hdr[9]) err_inc();
      else begin
        need = is_act ? 3 : 8;
        if (n - 1 < need) err_inc();
        else begin
          wr = 1'b1;
          for (int i = 0; i < need; i++) payload[i*DW +: DW] = pkt[i+1];
        end
      end
    end
    if (wr) begin
      e = '0;
      e[SB_W-2 -: 4] = addr;
      if (is_act) begin
        e[SB_W-1]  = 1'b1;
        e[624:0]   = payload[624:0];
        m_act_data = payload[624:0];
        m_act_addr = addr;
      end else begin
        e[2047:0]  = payload;
        m_cam_din  = payload[1023:0];
        m_cam_mask = payload[2047:1024];
        m_cam_addr = addr;
      end
      exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      send_word(pkt[i], i == n - 1);
      if (wr && i == need) begin
        if (is_act) check("act_strobe_latency", action_en, 1);
        else        check("cam_strobe_latency", lookup_din_en, 1);
      end
    end
    check("err_cnt", cfg_err_cnt, m_err);
    check("cam_hold", {lookup_din_mask, lookup_din, lookup_din_addr}, {m_cam_mask, m_cam_din, m_cam_addr});
    check("act_hold", {action_data_in, action_addr}, {m_act_data, m_act_addr});
  endtask

  task automatic do_reset();
    mon_en     = 1'b0;
    ctrl_valid = 1'b0;
    ctrl_last  = 1'b0;
    rst        = 1'b1;
    #1;
    check("rst_cam_outputs", {lookup_din_mask, lookup_din, lookup_din_addr, lookup_din_en}, 0);
    check("rst_act_outputs", {action_data_in, action_addr, action_en, ctrl_ready, cfg_err_cnt}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_err = '0;
    m_cam_din = '0;
    m_cam_mask = '0;
    m_cam_addr = '0;
    m_act_data = '0;
    m_act_addr = '0;
    exp_q.delete();
    check("ready_low_at_release", ctrl_ready, 0);
    @(negedge clk);
    check("ready_after_reset", ctrl_ready, 1);
    mon_en = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] w;
    int tgt, len, need, stage;
    @(negedge clk);
    do_reset();

    // CAM write: words 0x1..0x8
    pkt.delete();
    pkt.push_back(make_hdr(0, 0, 5));
    for (int i = 1; i <= 8; i++) begin
      w = DW'(i);
      pkt.push_back(w);
    end
    send_packet();
    check("cam_din_low_word", lookup_din[255:0], 1);
    check("cam_mask_low_word", lookup_din_mask[255:0], 5);
    check("cam_addr", lookup_din_addr, 5);

    // Action write: all ones
    pkt.delete();
    pkt.push_back(make_hdr(0, 1, 15));
    for (int i = 0; i < 3; i++) pkt.push_back({DW{1'b1}});
    send_packet();
    check("act_all_ones", action_data_in, {625{1'b1}});
    check("act_addr", action_addr, 15);

    // Foreign stage, 9 words total, then a normal CAM packet
    pkt.delete();
    pkt.push_back(make_hdr(3, 0, 2));
    for (int i = 0; i < 8; i++) pkt.push_back(rand_word());
    send_packet();
    pkt.delete();
    pkt.push_back(make_hdr(0, 0, 9));
    for (int i = 0; i < 8; i++) pkt.push_back(rand_word());
    send_packet();

    // Short CAM packet
    pkt.delete();
    pkt.push_back(make_hdr(0, 0, 1));
    for (int i = 0; i < 4; i++) pkt.push_back(rand_word());
    send_packet();
    check("short_err_is_one", cfg_err_cnt, 1);

    // Overlong action packet
    pkt.delete();
    pkt.push_back(make_hdr(0, 1, 6));
    for (int i = 0; i < 5; i++) pkt.push_back(rand_word());
    send_packet();

    // Reset after the third CAM payload word
    send_word(make_hdr(0, 0, 3), 1'b0);
    for (int i = 0; i < 3; i++) send_word(rand_word(), 1'b0);
    do_reset();
    pkt.delete();
    pkt.push_back(make_hdr(0, 0, 12));
    for (int i = 0; i < 8; i++) pkt.push_back(rand_word());
    send_packet();

    // Random packets
    for (int p = 0; p < 60; p++) begin
      stage = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 255) : 0;
      tgt = $urandom_range(0, 9);
      tgt = (tgt < 4) ? 0 : (tgt < 8) ? 1 : $urandom_range(2, 3);
      need = (tgt == 1) ? 3 : 8;
      len = ($urandom_range(0, 1) == 0) ? need : $urandom_range(0, 10);
      pkt.delete();
      pkt.push_back(make_hdr(stage, tgt, $urandom_range(0, 15)));
      for (int i = 0; i < len; i++) pkt.push_back(rand_word());
      send_packet();
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
